uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : UART receiver, mid-bit sampling; UART_RX_MAJORITY_SAMPLE_EN selects
//           2-of-3 majority sampling around the bit centre.          Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);

   localparam int BW = $clog2(DATA_WIDTH + 3);
   localparam logic [BW-1:0] C_BIT_ONE  = BW'(1);
   localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [5:0]              presc_q, presc_d;
   logic                    par_en_q, par_en_d;
   logic                    par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic                    perr_q, perr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    dv_q, dv_d;
   logic                    pe_q, pe_d;
   logic                    se_q, se_d;

   logic [5:0]              w_mid;
   logic                    w_decide;
   logic                    w_sample;

   assign w_mid = {1'b0, presc_q[5:1]};

`ifdef UART_RX_MAJORITY_SAMPLE_EN
   // Two early samples are held so the decision lands one cycle after centre.
   logic s0_q, s1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_q <= 1'b1;
         s1_q <= 1'b1;
      end else begin
         if (cnt_q == w_mid - 6'd1) s0_q <= RX_IN;
         if (cnt_q == w_mid)        s1_q <= RX_IN;
      end
   end

   assign w_decide = (cnt_q == w_mid + 6'd1);
   assign w_sample = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
`else
   assign w_decide = (cnt_q == w_mid);
   assign w_sample = RX_IN;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         bit_q     <= '0;
         presc_q   <= 6'd8;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         data_q    <= '0;
         dv_q      <= 1'b0;
         pe_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         presc_q   <= presc_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         shift_q   <= shift_d;
         perr_q    <= perr_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
         pe_q      <= pe_d;
         se_q      <= se_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      presc_d   = presc_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      shift_d   = shift_q;
      perr_d    = perr_q;
      data_d    = data_q;
      dv_d      = 1'b0;
      pe_d      = 1'b0;
      se_d      = 1'b0;

      if (state_q != IDLE) begin
         if (cnt_q == presc_q - 6'd1) begin
            cnt_d = 6'd0;
            bit_d = bit_q + C_BIT_ONE;
         end else begin
            cnt_d = cnt_q + 6'd1;
         end
      end

      case (state_q)
         IDLE: begin
            // The falling-edge cycle is edge count 0, so the next cycle is 1.
            if (!RX_IN) begin
               state_d   = START;
               cnt_d     = 6'd1;
               bit_d     = '0;
               presc_d   = Prescale;
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
               perr_d    = 1'b0;
            end
         end
         START: begin
            if (w_decide) state_d = w_sample ? IDLE : DATA;
         end
         DATA: begin
            if (w_decide) begin
               shift_d = {w_sample, shift_q[DATA_WIDTH-1:1]};
               if (bit_q == C_BIT_LAST) state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (w_decide) begin
               perr_d  = w_sample != (par_typ_q ? ~^shift_q : ^shift_q);
               state_d = STOP;
            end
         end
         STOP: begin
            if (w_decide) begin
               state_d = IDLE;
               pe_d    = perr_q;
               se_d    = ~w_sample;
               if (!perr_q && w_sample) begin
                  dv_d   = 1'b1;
                  data_d = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && state_d == IDLE) begin
         cnt_d = 6'd0;
         bit_d = '0;
      end
   end

   assign P_DATA     = data_q;
   assign Data_Valid = dv_q;
   assign Par_Err    = pe_q;
   assign Stp_Err    = se_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx : directed self-checking bench for uart_rx.             Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_SAMPLE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Par_Err;
   logic       Stp_Err;

   int checks = 0;
   int fails  = 0;

   logic line_q[$];
   int   dv_n, pe_n, se_n, dv_first, dv_last, pe_first, se_first;
   logic [7:0] pd_first, pd_last;
   logic [10:0] snap;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Par_Err    (Par_Err),
      .Stp_Err    (Stp_Err)
   );

   always #5 clk = ~clk;

   task automatic add_frame(input logic [7:0] d, input int p, input bit pe,
                            input logic pb, input logic sb);
      for (int i = 0; i < p; i++) line_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
         for (int i = 0; i < p; i++) line_q.push_back(d[b]);
      if (pe)
         for (int i = 0; i < p; i++) line_q.push_back(pb);
      for (int i = 0; i < p; i++) line_q.push_back(sb);
   endtask

   // Plays line_q one level per cycle starting at cycle 0, logging output pulses.
   task automatic run(input int extra, input int rst_cycle);
      int n;
      n = line_q.size() + extra;
      dv_n = 0; pe_n = 0; se_n = 0;
      dv_first = -1; dv_last = -1; pe_first = -1; se_first = -1;
      pd_first = 8'h00; pd_last = 8'h00; snap = '1;
      for (int c = 0; c < n; c++) begin
         RX_IN = (c < line_q.size()) ? line_q[c] : 1'b1;
         rst   = (c == rst_cycle);
         if (c == rst_cycle + 1) snap = {P_DATA, Data_Valid, Par_Err, Stp_Err};
         if (Data_Valid) begin
            dv_n++;
            if (dv_first < 0) begin dv_first = c; pd_first = P_DATA; end
            dv_last = c; pd_last = P_DATA;
         end
         if (Par_Err) begin pe_n++; if (pe_first < 0) pe_first = c; end
         if (Stp_Err) begin se_n++; if (se_first < 0) se_first = c; end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      line_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (P_DATA !== 8'h00) begin fails++; $display("FAIL reset_pdata got %h want 00", P_DATA); end
      checks++; if (Data_Valid !== 1'b0) begin fails++; $display("FAIL reset_dv got %b want 0", Data_Valid); end
      checks++; if (Par_Err !== 1'b0) begin fails++; $display("FAIL reset_pe got %b want 0", Par_Err); end
      checks++; if (Stp_Err !== 1'b0) begin fails++; $display("FAIL reset_se got %b want 0", Stp_Err); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      Prescale = 6'd8; PAR_EN = 1'b0;
      add_frame(8'hA5, 8, 0, 1'b0, 1'b1);
      run(12, -1);
      checks++; if (dv_first !== 77 + LAT) begin fails++; $display("FAIL basic_dv_cycle got %0d want %0d", dv_first, 77 + LAT); end
      checks++; if (pd_first !== 8'hA5) begin fails++; $display("FAIL basic_pdata got %h want a5", pd_first); end
      checks++; if (dv_n !== 1 || pe_n !== 0 || se_n !== 0) begin fails++; $display("FAIL basic_pulses got dv=%0d pe=%0d se=%0d want 1 0 0", dv_n, pe_n, se_n); end
   endtask

   task automatic test_parity();
      Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
      add_frame(8'h3C, 16, 1, 1'b0, 1'b1);
      run(20, -1);
      checks++; if (dv_first !== 169 + LAT) begin fails++; $display("FAIL par_even_dv_cycle got %0d want %0d", dv_first, 169 + LAT); end
      checks++; if (pd_first !== 8'h3C || pe_n !== 0) begin fails++; $display("FAIL par_even_ok got %h pe=%0d want 3c pe=0", pd_first, pe_n); end
      add_frame(8'h3C, 16, 1, 1'b1, 1'b1);
      run(20, -1);
      checks++; if (pe_first !== 169 + LAT || pe_n !== 1) begin fails++; $display("FAIL par_err_pulse got cyc=%0d n=%0d want %0d 1", pe_first, pe_n, 169 + LAT); end
      checks++; if (dv_n !== 0 || se_n !== 0 || P_DATA !== 8'h3C) begin fails++; $display("FAIL par_err_hold got dv=%0d se=%0d pdata=%h want 0 0 3c", dv_n, se_n, P_DATA); end
      PAR_TYP = 1'b1;
      add_frame(8'h07, 16, 1, 1'b0, 1'b1);
      run(20, -1);
      checks++; if (dv_n !== 1 || pd_first !== 8'h07 || pe_n !== 0) begin fails++; $display("FAIL par_odd got dv=%0d pdata=%h pe=%0d want 1 07 0", dv_n, pd_first, pe_n); end
   endtask

   task automatic test_glitch();
      Prescale = 6'd8; PAR_EN = 1'b0;
      line_q.push_back(1'b0); line_q.push_back(1'b0);
      run(24, -1);
      checks++; if (dv_n !== 0 || pe_n !== 0 || se_n !== 0) begin fails++; $display("FAIL glitch_pulses got dv=%0d pe=%0d se=%0d want 0 0 0", dv_n, pe_n, se_n); end
      add_frame(8'h5A, 8, 0, 1'b0, 1'b1);
      run(12, -1);
      checks++; if (dv_first !== 77 + LAT || pd_first !== 8'h5A) begin fails++; $display("FAIL glitch_next got cyc=%0d pdata=%h want %0d 5a", dv_first, pd_first, 77 + LAT); end
   endtask

   task automatic test_stop_err();
      Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
      add_frame(8'h55, 8, 0, 1'b0, 1'b0);
      run(12, -1);
      checks++; if (se_first !== 77 + LAT || se_n !== 1) begin fails++; $display("FAIL stop_err_pulse got cyc=%0d n=%0d want %0d 1", se_first, se_n, 77 + LAT); end
      checks++; if (dv_n !== 0 || pe_n !== 0 || P_DATA !== 8'h5A) begin fails++; $display("FAIL stop_err_hold got dv=%0d pe=%0d pdata=%h want 0 0 5a", dv_n, pe_n, P_DATA); end
      PAR_EN = 1'b1;
      add_frame(8'h55, 8, 1, 1'b1, 1'b0);
      run(12, -1);
      checks++; if (pe_first !== 85 + LAT || se_first !== 85 + LAT || dv_n !== 0) begin fails++; $display("FAIL both_err got pe=%0d se=%0d dv=%0d want %0d %0d 0", pe_first, se_first, dv_n, 85 + LAT, 85 + LAT); end
   endtask

   task automatic test_reset_mid();
      Prescale = 6'd8; PAR_EN = 1'b0;
      add_frame(8'hA5, 8, 0, 1'b0, 1'b1);
      while (line_q.size() > 43) void'(line_q.pop_back());
      run(40, 42);
      checks++; if (snap !== 11'h000) begin fails++; $display("FAIL reset_mid_outputs got %h want 000", snap); end
      checks++; if (dv_n !== 0 || pe_n !== 0 || se_n !== 0) begin fails++; $display("FAIL reset_mid_pulses got dv=%0d pe=%0d se=%0d want 0 0 0", dv_n, pe_n, se_n); end
      add_frame(8'h81, 8, 0, 1'b0, 1'b1);
      run(12, -1);
      checks++; if (dv_first !== 77 + LAT || pd_first !== 8'h81) begin fails++; $display("FAIL reset_mid_next got cyc=%0d pdata=%h want %0d 81", dv_first, pd_first, 77 + LAT); end
   endtask

   task automatic test_back_to_back();
      Prescale = 6'd8; PAR_EN = 1'b0;
      add_frame(8'h12, 8, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3 - LAT; i++) void'(line_q.pop_back());
      add_frame(8'h34, 8, 0, 1'b0, 1'b1);
      run(12, -1);
      checks++; if (dv_n !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", dv_n); end
      checks++; if (dv_first !== 77 + LAT || pd_first !== 8'h12) begin fails++; $display("FAIL b2b_first got cyc=%0d pdata=%h want %0d 12", dv_first, pd_first, 77 + LAT); end
      checks++; if (dv_last !== 2 * (77 + LAT) || pd_last !== 8'h34) begin fails++; $display("FAIL b2b_second got cyc=%0d pdata=%h want %0d 34", dv_last, pd_last, 2 * (77 + LAT)); end
   endtask

`ifdef UART_RX_MAJORITY_SAMPLE_EN
   task automatic test_majority();
      Prescale = 6'd16; PAR_EN = 1'b0;
      add_frame(8'hC3, 16, 0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) line_q[k * 16 + 8] = ~line_q[k * 16 + 8];
      run(20, -1);
      checks++; if (dv_first !== 154 || pd_first !== 8'hC3) begin fails++; $display("FAIL majority got cyc=%0d pdata=%h want 154 c3", dv_first, pd_first); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_glitch();
      test_stop_err();
      test_reset_mid();
      test_back_to_back();
`ifdef UART_RX_MAJORITY_SAMPLE_EN
      test_majority();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
